// File: rtl/sb_pattern_gen.sv
// -----------------------------------------------------------------------------
// sb_pattern_gen
// Sideband clock-pattern generator for the UCIe SBINIT step. Once started it
// offers PATTERN to the sideband serializer on every serializer-ready cycle.
// After the receive detector reports the pattern, it sends EXTRA_ITERATIONS
// more words (the word accepted in the detect cycle counts toward them) and
// then holds o_start_pattern_done.
//
// Build option:
//   SB_PATTERN_GEN_TIMEOUT_EN  defined: SEND/EXTRA give up after
//                              TIMEOUT_CYCLES and pulse o_pattern_time_out.
//                              undefined: no timeout counter, SEND waits
//                              for detection indefinitely, o_pattern_time_out=0.
//
// Ports:
//   i_clk                      in   1   clock, rising edge
//   i_rst_n                    in   1   asynchronous active-low reset
//   i_start_pattern_req        in   1   start request (pulse is enough)
//   i_rx_sb_pattern_samp_done  in   1   RX detector saw the pattern
//   i_ser_done                 in   1   serializer accepts a word this cycle
//   o_start_pattern_done       out  1   sequence complete (level)
//   o_pattern                  out  64  PATTERN while valid, else 0
//   o_pattern_time_out         out  1   timeout (1-cycle pulse)
//   o_pattern_valid            out  1   word offered (combinational)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start request
// SEND   | streaming pattern, waiting for RX detection
// EXTRA  | detection seen, counting the trailing words
// DONE   | sequence complete, done held until the next start
// -----------------------------------------------------------------------------
module sb_pattern_gen #(
  parameter logic [63:0] PATTERN          = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter int unsigned EXTRA_ITERATIONS = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 8000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_pattern_req,
  input  logic        i_rx_sb_pattern_samp_done,
  input  logic        i_ser_done,
  output logic        o_start_pattern_done,
  output logic [63:0] o_pattern,
  output logic        o_pattern_time_out,
  output logic        o_pattern_valid
);

  localparam int ITER_W = $clog2(EXTRA_ITERATIONS + 1);
  // Iteration value held just before the final handshake.
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(EXTRA_ITERATIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_EXTRA = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ITER_W-1:0] iter_cnt, iter_nxt;
  logic              done_q, done_nxt;
  logic              to_q, to_nxt;
  logic              handshake;
  logic              tmo_expire;

  assign o_pattern_valid      = ((state == ST_SEND) || (state == ST_EXTRA)) && i_ser_done;
  assign o_pattern            = o_pattern_valid ? PATTERN : 64'h0;
  assign o_start_pattern_done = done_q;
  assign o_pattern_time_out   = to_q;
  assign handshake            = o_pattern_valid;

`ifdef SB_PATTERN_GEN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             tmo_clr, tmo_run;

  // Counter restarts on every accepted start and runs through SEND and EXTRA.
  assign tmo_clr    = ((state == ST_IDLE) || (state == ST_DONE)) && i_start_pattern_req;
  assign tmo_run    = (state == ST_SEND) || (state == ST_EXTRA);
  assign tmo_expire = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_nxt = tmo_cnt;
    if (tmo_clr) begin
      tmo_nxt = '0;
    end else if (tmo_run) begin
      tmo_nxt = tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_nxt;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expire         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    done_nxt  = done_q;
    to_nxt    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start_pattern_req) begin
          state_nxt = ST_SEND;
          iter_nxt  = '0;
          done_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        // Detection beats an expiring timer on the same edge.
        if (i_rx_sb_pattern_samp_done) begin
          if (handshake && (ITER_LAST == '0)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            iter_nxt  = '0;
          end else begin
            state_nxt = ST_EXTRA;
            iter_nxt  = handshake ? ITER_W'(1) : '0;
          end
        end else if (tmo_expire) begin
          state_nxt = ST_IDLE;
          to_nxt    = 1'b1;
        end
      end
      ST_EXTRA: begin
        if (handshake && (iter_cnt == ITER_LAST)) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          iter_nxt  = '0;
        end else if (tmo_expire) begin
          state_nxt = ST_IDLE;
          to_nxt    = 1'b1;
          iter_nxt  = '0;
        end else if (handshake) begin
          iter_nxt = iter_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      done_q   <= done_nxt;
      to_q     <= to_nxt;
    end
  end

endmodule

// File: tb/tb_sb_pattern_gen.sv
module tb_sb_pattern_gen;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        samp = 1'b0;
  logic        ser = 1'b0;
  logic        done;
  logic [63:0] pattern;
  logic        time_out;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  sb_pattern_gen #(
    .PATTERN(PAT),
    .EXTRA_ITERATIONS(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start_pattern_req(start),
    .i_rx_sb_pattern_samp_done(samp),
    .i_ser_done(ser),
    .o_start_pattern_done(done),
    .o_pattern(pattern),
    .o_pattern_time_out(time_out),
    .o_pattern_valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic start, samp, ser;
    logic exp_valid, exp_done, exp_to;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int hs, bad, pulses, first_k;
    logic seen_done;

    // {start, samp, ser, exp_valid, exp_done, exp_to}
    vecs[0]  = '{1, 0, 1, 0, 0, 0};  // IDLE, start accepted
    vecs[1]  = '{0, 0, 1, 1, 0, 0};  // SEND
    vecs[2]  = '{0, 0, 0, 0, 0, 0};  // SEND stalled
    vecs[3]  = '{0, 1, 1, 1, 0, 0};  // detect with handshake -> count 1
    vecs[4]  = '{0, 0, 1, 1, 0, 0};  // 2
    vecs[5]  = '{0, 0, 0, 0, 0, 0};  // stall, no advance
    vecs[6]  = '{0, 0, 1, 1, 0, 0};  // 3
    vecs[7]  = '{0, 1, 1, 1, 0, 0};  // 4 -> DONE, samp ignored
    vecs[8]  = '{0, 0, 1, 0, 1, 0};  // DONE
    vecs[9]  = '{0, 0, 1, 0, 1, 0};
    vecs[10] = '{1, 0, 1, 0, 1, 0};  // restart from DONE
    vecs[11] = '{0, 0, 1, 1, 0, 0};
    vecs[12] = '{1, 0, 1, 1, 0, 0};  // start in SEND ignored
    vecs[13] = '{0, 1, 0, 0, 0, 0};  // detect without handshake -> count 0
    vecs[14] = '{0, 0, 1, 1, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 0, 0};
    vecs[16] = '{0, 0, 1, 1, 0, 0};
    vecs[17] = '{0, 0, 1, 1, 0, 0};  // fourth handshake -> DONE
    vecs[18] = '{0, 0, 1, 0, 1, 0};

    // Reset
    rst_n = 1'b0;
    ser = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_pattern", pattern, 0);
    check("rst_done", done, 0);
    check("rst_to", time_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ser = 1'b0;

    // Table vectors, one per cycle
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      samp  = vecs[i].samp;
      ser   = vecs[i].ser;
      #1;
      check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_pattern", i), pattern, vecs[i].exp_valid ? PAT : 64'h0);
      check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d_to", i), time_out, vecs[i].exp_to);
    end

    // Normal flow: start, detect 11 cycles later, count handshakes to done
    @(negedge clk);
    start = 1'b1; samp = 1'b0; ser = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    samp = 1'b1;
    hs = 0; bad = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      #1;
      if (done) seen_done = 1'b1;
      else if (valid) begin
        hs++;
        if (pattern !== PAT) bad++;
      end
      @(negedge clk);
      samp = 1'b0;
    end
    check("normal_done_seen", seen_done, 1);
    check("normal_handshakes", hs, 4);
    check("normal_pattern_bad", bad, 0);
    repeat (5) @(negedge clk);
    #1;
    check("normal_done_held", done, 1);
    check("normal_valid_after", valid, 0);

    // Backpressure: random serializer ready over many restarted rounds
    bad = 0;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      start = 1'b1; samp = 1'b0; ser = 1'($urandom_range(0, 1));
      #1;
      if (ser == 1'b0 && valid) bad++;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start = 1'b0; ser = 1'($urandom_range(0, 1));
        #1;
        if (ser == 1'b0 && valid) bad++;
      end
      @(negedge clk);
      samp = 1'b1;
      hs = 0; seen_done = 1'b0;
      for (int c = 0; c < 80 && !seen_done; c++) begin
        ser = 1'($urandom_range(0, 1));
        #1;
        if (ser == 1'b0 && valid) bad++;
        if (done) seen_done = 1'b1;
        else if (valid) hs++;
        @(negedge clk);
        samp = 1'b0;
      end
      check($sformatf("bp%0d_done", r), seen_done, 1);
      check($sformatf("bp%0d_handshakes", r), hs, 4);
      for (int c = 0; c < 60; c++) begin
        ser = 1'($urandom_range(0, 1));
        #1;
        if (valid) bad++;
        @(negedge clk);
      end
    end
    check("bp_valid_without_ready", bad, 0);

`ifdef SB_PATTERN_GEN_TIMEOUT_EN
    // Timeout: no detection; pulse after edge start+TMO
    @(negedge clk);
    start = 1'b1; ser = 1'b1; samp = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; first_k = -1; bad = 0;
    for (int k = 1; k <= TMO + 2; k++) begin
      @(negedge clk);
      #1;
      if (time_out) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (done) bad++;
    end
    check("tmo_pulse_edge", first_k, TMO);
    check("tmo_pulse_count", pulses, 1);
    check("tmo_valid_after", valid, 0);
    check("tmo_done_never", bad, 0);

    // Detection on the expiry edge wins
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < TMO; k++) @(negedge clk);
    samp = 1'b1;
    pulses = 0;
    @(negedge clk);
    samp = 1'b0;
    #1;
    if (time_out) pulses++;
    check("race_in_extra_valid", valid, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      if (time_out) pulses++;
    end
    check("race_no_timeout", pulses, 0);
    check("race_done", done, 1);
`else
    // No timeout build: pattern streams indefinitely
    @(negedge clk);
    start = 1'b1; ser = 1'b1; samp = 1'b0;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; bad = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      #1;
      if (time_out) pulses++;
      if (!valid || pattern !== PAT) bad++;
    end
    check("notmo_no_pulse", pulses, 0);
    check("notmo_pattern_continues", bad, 0);
`endif

    // Reset mid-EXTRA
    @(negedge clk);
    start = 1'b1; ser = 1'b1; samp = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    samp = 1'b1;
    @(negedge clk);
    samp = 1'b0;
    #1;
    check("midx_in_extra", valid, 1);
    rst_n = 1'b0;
    #1;
    check("midx_rst_valid", valid, 0);
    check("midx_rst_pattern", pattern, 0);
    check("midx_rst_done", done, 0);
    check("midx_rst_to", time_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; bad = 0;
    for (int k = 0; k < TMO + 20; k++) begin
      @(negedge clk);
      #1;
      if (time_out) pulses++;
      if (valid || done) bad++;
    end
    check("midx_no_timeout", pulses, 0);
    check("midx_stays_idle", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
